// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl
// Purpose : Stall/flush controller for the 5-stage RV32I pipeline registers.
// Rev     : 1.0
// ============================================================================
module pipeline_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  input  logic             imem_valid_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             mem_wb_flush_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_MEM_WAIT   = 2'd2,
    S_ERROR      = 2'd3
  } state_e;

  state_e              state_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                err_q;
  logic [CNT_W-1:0]    stall_q;
  logic [CNT_W-1:0]    flush_q;

  logic                w_mem_wait;
  logic                w_hazard;
  logic                w_active;
  logic                w_branch_fire;
  logic [WAIT_W-1:0]   w_wait_inc;

  assign w_mem_wait    = mem_req_i & ~mem_ack_i;
  assign w_hazard      = ex_mem_read_i & (ex_rd_i != 5'd0) &
                         ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                          (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
  assign w_active      = ~rst & ((state_q == S_RUN) | (state_q == S_MEM_WAIT));
  assign w_branch_fire = w_active & ~w_mem_wait & ex_branch_taken_i;
  // The entry cycle from RUN counts as the first wait cycle.
  assign w_wait_inc    = ((state_q == S_MEM_WAIT) ? wait_q : '0) + WAIT_W'(1);

  always_comb begin
    pc_en_o        = 1'b0;
    if_id_en_o     = 1'b0;
    id_ex_en_o     = 1'b0;
    ex_mem_en_o    = 1'b0;
    mem_wb_en_o    = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    mem_wb_flush_o = 1'b0;
    if (rst || state_q == S_RESET_HOLD) begin
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else if (w_active) begin
      if (w_mem_wait) begin
        mem_wb_en_o    = 1'b1;
        mem_wb_flush_o = 1'b1;
      end else if (ex_branch_taken_i) begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (w_hazard) begin
        id_ex_en_o    = 1'b1;
        id_ex_flush_o = 1'b1;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;
      end else if (!imem_valid_i) begin
        if_id_en_o    = 1'b1;
        if_id_flush_o = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;
      end else begin
        pc_en_o     = 1'b1;
        if_id_en_o  = 1'b1;
        id_ex_en_o  = 1'b1;
        ex_mem_en_o = 1'b1;
        mem_wb_en_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET_HOLD;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (w_active && !pc_en_o && !(&stall_q)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (w_branch_fire && !(&flush_q)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
      case (state_q)
        S_RESET_HOLD: begin
          state_q <= S_RUN;
          wait_q  <= '0;
        end
        S_RUN, S_MEM_WAIT: begin
          if (w_mem_wait) begin
            wait_q <= w_wait_inc;
            if (w_wait_inc >= WAIT_W'(MEM_TIMEOUT)) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_MEM_WAIT;
            end
          end else begin
            wait_q  <= '0;
            state_q <= S_RUN;
          end
        end
        default: begin
          state_q <= S_ERROR;
        end
      endcase
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_ctrl
// Purpose : Self-checking bench for pipeline_ctrl (default and small configs).
// Rev     : 1.0
// ============================================================================
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       rs1_used, rs2_used, ex_mr, br, mreq, mack, ivalid;

  // Output vectors: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, mem_wb_fl}
  wire [7:0]  out_a, out_b;
  wire        err_a, err_b;
  wire [31:0] stall_a, flush_a;
  wire [2:0]  stall_b, flush_b;

  pipeline_ctrl #(.CNT_W(32), .MEM_TIMEOUT(64)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mr), .ex_branch_taken_i(br),
    .mem_req_i(mreq), .mem_ack_i(mack), .imem_valid_i(ivalid),
    .pc_en_o(out_a[7]), .if_id_en_o(out_a[6]), .id_ex_en_o(out_a[5]),
    .ex_mem_en_o(out_a[4]), .mem_wb_en_o(out_a[3]),
    .if_id_flush_o(out_a[2]), .id_ex_flush_o(out_a[1]), .mem_wb_flush_o(out_a[0]),
    .err_o(err_a), .stall_cnt_o(stall_a), .flush_cnt_o(flush_a)
  );

  pipeline_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mr), .ex_branch_taken_i(br),
    .mem_req_i(mreq), .mem_ack_i(mack), .imem_valid_i(ivalid),
    .pc_en_o(out_b[7]), .if_id_en_o(out_b[6]), .id_ex_en_o(out_b[5]),
    .ex_mem_en_o(out_b[4]), .mem_wb_en_o(out_b[3]),
    .if_id_flush_o(out_b[2]), .id_ex_flush_o(out_b[1]), .mem_wb_flush_o(out_b[0]),
    .err_o(err_b), .stall_cnt_o(stall_b), .flush_cnt_o(flush_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 = post-reset hold, 1 = operating, 2 = error.
  // Waiting is implied by a non-zero count of consecutive unacked cycles.
  int     m_phase[2]   = '{0, 0};
  int     m_waits[2]   = '{0, 0};
  longint m_stall[2]   = '{0, 0};
  longint m_flush[2]   = '{0, 0};
  bit     m_err[2]     = '{0, 0};
  int     c_timeout[2] = '{64, 4};
  longint c_max[2]     = '{64'd4294967295, 64'd7};

  function automatic logic [7:0] exp_outs(input int ph);
    bit hz;
    hz = ex_mr && ex_rd != 0 &&
         ((rs1_used && id_rs1 == ex_rd) || (rs2_used && id_rs2 == ex_rd));
    if (rst || ph == 0)   return 8'b00000_111;
    if (ph == 2)          return 8'b00000_000;
    if (mreq && !mack)    return 8'b00001_001;
    if (br)               return 8'b11111_110;
    if (hz)               return 8'b00111_010;
    if (!ivalid)          return 8'b01111_100;
    return 8'b11111_000;
  endfunction

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_update(input int k, input logic [7:0] e);
    if (rst) begin
      m_phase[k] = 0; m_waits[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_err[k] = 0;
    end else if (m_phase[k] == 0) begin
      m_phase[k] = 1;
    end else if (m_phase[k] == 1) begin
      if (!e[7]) m_stall[k] = sat_inc(m_stall[k], c_max[k]);
      if (mreq && !mack) begin
        m_waits[k]++;
        if (m_waits[k] >= c_timeout[k]) begin
          m_phase[k] = 2;
          m_err[k]   = 1;
        end
      end else begin
        m_waits[k] = 0;
        if (br) m_flush[k] = sat_inc(m_flush[k], c_max[k]);
      end
    end
  endtask

  // One clock: compare both DUTs against the model mid-cycle, then advance.
  task automatic cyc(output logic [7:0] va, output logic [7:0] vb);
    logic [7:0] e[2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e[k] = exp_outs(m_phase[k]);
      check($sformatf("outs%0d", k), (k == 0) ? out_a : out_b, e[k]);
      check($sformatf("err%0d", k), (k == 0) ? err_a : err_b, m_err[k]);
      check($sformatf("stall%0d", k), (k == 0) ? stall_a : stall_b, m_stall[k]);
      check($sformatf("flush%0d", k), (k == 0) ? flush_a : flush_b, m_flush[k]);
    end
    va = out_a;
    vb = out_b;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, e[k]);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; rs1_used = 0; rs2_used = 0;
    ex_mr = 0; br = 0; mreq = 0; mack = 0; ivalid = 1;
  endtask

  task automatic do_reset();
    logic [7:0] va, vb;
    rst = 1; cyc(va, vb);
    rst = 0; cyc(va, vb);
  endtask

  logic [7:0] va, vb;

  initial begin
    rst = 1;
    idle();
    // Reset release
    repeat (3) cyc(va, vb);
    check("rst_stall", stall_a, 0);
    rst = 0;
    cyc(va, vb);
    check("hold_outs", va, 8'b00000_111);
    cyc(va, vb);
    check("run_outs", va, 8'b11111_000);
    check("run_stall", stall_a, 0);
    check("run_flush", flush_a, 0);

    // Load-use on x5, then x0
    ex_mr = 1; ex_rd = 5; id_rs2 = 5; rs2_used = 1;
    cyc(va, vb);
    check("lu_outs", va, 8'b00111_010);
    check("lu_stall", stall_a, 1);
    idle();
    cyc(va, vb);
    check("lu_after", va, 8'b11111_000);
    ex_mr = 1; ex_rd = 0; id_rs2 = 0; rs2_used = 1;
    cyc(va, vb);
    check("x0_outs", va, 8'b11111_000);
    check("x0_stall", stall_a, 1);

    // Branch plus hazard
    do_reset();
    idle();
    ex_mr = 1; ex_rd = 5; id_rs1 = 5; rs1_used = 1; br = 1;
    cyc(va, vb);
    check("brhz_outs", va, 8'b11111_110);
    check("brhz_flush", flush_a, 1);
    check("brhz_stall", stall_a, 0);

    // Memory wait with branch pending throughout
    idle();
    do_reset();
    br = 1; mreq = 1; mack = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(va, vb);
      check("mw_outs", va, 8'b00001_001);
    end
    mack = 1;
    cyc(va, vb);
    check("mw_ack_outs", va, 8'b11111_110);
    check("mw_flush", flush_a, 1);
    check("mw_stall", stall_a, 4);

    // Timeout on the MEM_TIMEOUT=4 instance
    idle();
    do_reset();
    mreq = 1; mack = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc(va, vb);
      check("to_err", err_b, (i == 4) ? 1 : 0);
    end
    cyc(va, vb);
    check("to_outs", vb, 8'b00000_000);
    mack = 1;
    cyc(va, vb);
    check("to_ack_outs", vb, 8'b00000_000);
    check("to_ack_err", err_b, 1);
    idle();
    do_reset();
    check("to_rst_err", err_b, 0);

    // Counter saturation on the CNT_W=3 instance
    ivalid = 0;
    repeat (10) cyc(va, vb);
    check("sat_small", stall_b, 7);
    check("sat_big", stall_a, 10);

    // Randomized traffic against the model
    idle();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(99) == 0);
      id_rs1   = 5'($urandom_range(7));
      id_rs2   = 5'($urandom_range(7));
      ex_rd    = 5'($urandom_range(7));
      rs1_used = 1'($urandom_range(1));
      rs2_used = 1'($urandom_range(1));
      ex_mr    = ($urandom_range(9) < 4);
      br       = ($urandom_range(9) < 2);
      mreq     = ($urandom_range(9) < 4);
      mack     = ($urandom_range(9) < 4);
      ivalid   = ($urandom_range(9) < 8);
      cyc(va, vb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
